// File: rtl/multiplier_datapath_taint_track_word.sv
// Shift-add multiplier datapath (multiplicand, multiplier and running-sum registers) with optional
// word-level taint tracking, enabled by defining the macro TAINT_TRACK_EN.
module multiplier_datapath_taint_track_word #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic                 multiplicand_t,
   input  logic [WIDTH-1:0]     multiplier,
   input  logic                 multiplier_t,
   input  logic                 mdld,
   input  logic                 mdld_t,
   input  logic                 mrld,
   input  logic                 mrld_t,
   input  logic                 rsclear,
   input  logic                 rsclear_t,
   input  logic                 rsload,
   input  logic                 rsload_t,
   input  logic                 rsshr,
   input  logic                 rsshr_t,
   output logic [WIDTH-1:0]     multiplierReg,
   output logic                 multiplierReg_t,
   output logic [2*WIDTH-1:0]   product,
   output logic                 product_t
);

   logic [WIDTH-1:0] md_reg;
   logic [WIDTH-1:0] mr_reg;
   logic [2*WIDTH:0] rs;

   // Upper running-sum half plus multiplicand; WIDTH+1 bits so the carry lands in rs[2*WIDTH].
   function automatic logic [WIDTH:0] add_upper(input logic [WIDTH:0] upper,
                                                input logic [WIDTH-1:0] md);
      return upper + {1'b0, md};
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         md_reg <= '0;
         mr_reg <= '0;
         rs     <= '0;
      end else begin
         if (mdld) md_reg <= multiplicand;
         if (mrld) mr_reg <= multiplier;
         if (rsclear)
            rs <= '0;
         else if (rsload)
            rs[2*WIDTH:WIDTH] <= add_upper(rs[2*WIDTH:WIDTH], md_reg);
         else if (rsshr)
            rs <= {1'b0, rs[2*WIDTH:1]};
      end
   end

   assign multiplierReg = mr_reg;
   assign product       = rs[2*WIDTH-1:0];

`ifdef TAINT_TRACK_EN
   logic md_t;
   logic mr_t;
   logic rs_t;
   logic rs_base_t;

   // A tainted enable taints its destination whether or not it fires (implicit flow).
   always_comb begin
      rs_base_t = rs_t;
      if (rsclear)
         rs_base_t = 1'b0;
      else if (rsload)
         rs_base_t = rs_t | md_t;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         md_t <= 1'b0;
         mr_t <= 1'b0;
         rs_t <= 1'b0;
      end else begin
         md_t <= (mdld ? multiplicand_t : md_t) | mdld_t;
         mr_t <= (mrld ? multiplier_t : mr_t) | mrld_t;
         rs_t <= rs_base_t | rsclear_t | rsload_t | rsshr_t;
      end
   end

   assign multiplierReg_t = mr_t;
   assign product_t       = rs_t;
`else
   logic unused_taint_inputs;
   assign unused_taint_inputs = ^{multiplicand_t, multiplier_t, mdld_t, mrld_t,
                                  rsclear_t, rsload_t, rsshr_t};
   assign multiplierReg_t = 1'b0;
   assign product_t       = 1'b0;
`endif

endmodule

// File: doc/multiplier_datapath_taint_track_word.md
MULTIPLIER_DATAPATH_TAINT_TRACK_WORD -- requirements
Module: multiplier_datapath_taint_track_word

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; product is 2*WIDTH bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 multiplicand, multiplier  input  WIDTH  operand data; multiplicand_t, multiplier_t  input  1  word taint of each.
REQ-005 mdld/mdld_t, mrld/mrld_t  input  1 each  load multiplicand/multiplier register, plus enable taint.
REQ-006 rsclear/rsclear_t, rsload/rsload_t, rsshr/rsshr_t  input  1 each  running-sum clear/add/shift-right, plus enable taint.
REQ-007 multiplierReg  output  WIDTH  registered multiplier, returned to control; multiplierReg_t  output  1  its taint.
REQ-008 product  output  2*WIDTH  running-sum bits [2*WIDTH-1:0]; product_t  output  1  running-sum taint.

Function
REQ-009 Registers: mdReg[WIDTH-1:0], mrReg[WIDTH-1:0], rs[2*WIDTH:0] (bit 2*WIDTH = carry), each with one word-taint bit.
REQ-010 mdld=1: mdReg <= multiplicand next edge; mrld=1: mrReg <= multiplier; both may load in the same cycle.
REQ-011 Running-sum priority, one op per cycle: rsclear > rsload > rsshr > hold.
REQ-012 rsclear: rs <= 0.
REQ-013 rsload: rs[2*WIDTH:WIDTH] <= rs[2*WIDTH:WIDTH] + mdReg, (WIDTH+1)-bit result; rs[WIDTH-1:0] unchanged.
REQ-014 rsshr: rs <= {1'b0, rs[2*WIDTH:1]} (logical shift right, carry shifts in).
REQ-015 Control sequence clear, then per bit i=0..WIDTH-1 {shift; load if mrReg[i]}, then final shift SHALL leave product = mdReg*mrReg exactly, including all-ones operands.
REQ-016 Outputs are register-driven: product and multiplierReg change only on clk edge or reset; zero combinational input-to-output paths.
REQ-017 Taint, data regs: reg_t_next = (ld ? data_t : reg_t) | ld_t, for mdReg (mdld, multiplicand_t) and mrReg (mrld, multiplier_t).
REQ-018 Taint, rs: base = 0 if rsclear; rs_t | mdReg_t if rsload; rs_t otherwise; rs_t_next = base | rsclear_t | rsload_t | rsshr_t.
REQ-019 Tainted enable taints destination even when enable=0 (implicit flow); rs taint clears only via reset or untainted rsclear with rsload_t=rsshr_t=0.
REQ-020 multiplierReg_t = mrReg taint; product_t = rs taint.

Reset
REQ-021 rst=1 asynchronously clears mdReg, mrReg, rs and all taint bits; product=0, product_t=0, multiplierReg=0, multiplierReg_t=0 while rst high.
REQ-022 Reset mid-multiplication abandons the operation; first edge after deassertion obeys REQ-010..REQ-019 from all-zero state.

Configuration
REQ-023 Macro TAINT_TRACK_EN: defined -> taint registers and logic per REQ-017..REQ-020.
REQ-024 TAINT_TRACK_EN undefined -> no taint registers; product_t and multiplierReg_t tied 0; *_t inputs ignored; data behaviour identical.

Verification (WIDTH=4, TAINT_TRACK_EN defined unless noted)
REQ-025 md=13, mr=11, full control sequence, no taints -> product=143, product_t=0, multiplierReg=11.
REQ-026 md=15, mr=15 -> carry bit used, product=225; md=0, mr=9 -> product=0.
REQ-027 multiplicand_t=1 on mdld, rsload once -> product_t=1 from that edge; multiplierReg_t stays 0.
REQ-028 mdld=0, mdld_t=1 one cycle -> mdReg unchanged, mdReg taint=1; rsshr_t=1 with rsshr=0 -> product_t=1, product unchanged; untainted rsclear -> product=0, product_t=0.
REQ-029 rst asserted between edges mid-sequence -> product=0, all taints 0 immediately; next 6*7=42 run correct.
REQ-030 TAINT_TRACK_EN undefined, all *_t inputs=1 -> product_t=multiplierReg_t=0; 13*11=143.
